// File: rtl/ad9866_spi_responder.sv
// AD9866 serial-port responder: decodes 16-bit SPI frames into a 32x8 shadow
// register file and answers read frames on sdo.
// Optional feature macro: AD9866_SPI_RESP_READBACK_EN (enables read frames on sdo).
module ad9866_spi_responder #(
  parameter int unsigned NREG = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          sen_n,
  input  logic          sdio,
  output logic          sdo,
  output logic          sdo_oe,
  output logic          wr_stb,
  output logic [6:0]    wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  instr;
  logic [7:0]  regs [NREG];

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sen_s1, sen_s2, sen_s3;
  logic sdio_s1, sdio_s2;
  logic sclk_rise, sen_fall, sen_rise;

  // Synchronizers; sen stages reset low so a frame already in flight at reset release is never seen as starting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {sen_s1, sen_s2, sen_s3}    <= 3'b000;
      {sdio_s1, sdio_s2}          <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {sclk, sclk_s1, sclk_s2};
      {sen_s1, sen_s2, sen_s3}    <= {sen_n, sen_s1, sen_s2};
      {sdio_s1, sdio_s2}          <= {sdio, sdio_s1};
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sen_fall  = ~sen_s2 & sen_s3;
  assign sen_rise  = sen_s2 & ~sen_s3;

  // Frame decoder FSM with registered write-commit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      instr   <= 8'h00;
      wr_stb  <= 1'b0;
      wr_addr <= 7'h00;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (sen_rise) begin
        state <= IDLE;
      end else if (sen_fall) begin
        state   <= INSTR;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          INSTR: if (sclk_rise) begin
            shreg   <= {shreg[6:0], sdio_s2};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              instr <= {shreg[6:0], sdio_s2};
              state <= DATA;
            end
          end
          DATA: if (sclk_rise) begin
            shreg   <= {shreg[6:0], sdio_s2};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state <= DONE;
              if (!instr[7]) begin
                wr_stb  <= 1'b1;
                wr_addr <= instr[6:0];
                wr_data <= {shreg[6:0], sdio_s2};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file update one cycle behind the decoder so a same-cycle local read sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= 8'h00;
    end else if (wr_stb && (32'(wr_addr) < NREG)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = regs[rd_addr];

`ifdef AD9866_SPI_RESP_READBACK_EN
  logic       sclk_fall;
  logic [7:0] snap;
  logic [6:0] rd_frame_addr;

  assign sclk_fall     = ~sclk_s2 & sclk_s3;
  assign rd_frame_addr = {shreg[5:0], sdio_s2};

  // Read path: snapshot on the 8th rising edge, shift out MSB first on data-phase falling edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdo    <= 1'b0;
      sdo_oe <= 1'b0;
      snap   <= 8'h00;
    end else if (sen_rise) begin
      sdo    <= 1'b0;
      sdo_oe <= 1'b0;
    end else if (sen_fall) begin
      sdo_oe <= 1'b0;
    end else if (state == INSTR && sclk_rise && bit_cnt == 4'd7) begin
      snap <= (shreg[6] && (32'(rd_frame_addr) < NREG)) ? regs[rd_frame_addr[AW-1:0]] : 8'h00;
    end else if (state == DATA && sclk_fall && instr[7]) begin
      sdo    <= snap[7];
      snap   <= {snap[6:0], 1'b0};
      sdo_oe <= 1'b1;
    end
  end
`else
  assign sdo    = 1'b0;
  assign sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Self-checking bench for ad9866_spi_responder: SPI master model, write/read
// scoreboards and a local register model.
`timescale 1ns/1ps
module tb_ad9866_spi_responder;

  localparam int HALF = 6;  // clk cycles per sclk half period
`ifdef AD9866_SPI_RESP_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       sen_n = 1'b1;
  logic       sdio = 1'b0;
  logic       sdo, sdo_oe, wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] model [32];

  int n_vec = 0;
  int n_err = 0;

  ad9866_spi_responder #(.NREG(32)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sen_n(sen_n), .sdio(sdio),
    .sdo(sdo), .sdo_oe(sdo_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit; returns sdo as seen just before the rising edge
  task automatic xfer_bit(input logic b, output logic so);
    sdio = b;
    wait_clk(HALF);
    so = sdo;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, input int extra);
    logic       so;
    logic       rd_full;
    logic [7:0] rx;
    logic [7:0] exp;
    rd_full = w[15] && (nbits >= 16);
    exp = (w[14:8] < 7'd32) ? model[w[12:8]] : 8'h00;
    if (rd_full && RB) rd_q.push_back(exp);
    rx = 8'h00;
    sen_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(w[15-i], so);
      if (w[15] && i >= 8 && i <= 15) begin
        rx = {rx[6:0], so};
        chk("sdo_oe_bit", 32'(sdo_oe), 32'(RB));
      end
    end
    for (int i = 0; i < extra; i++) xfer_bit(1'($urandom_range(1)), so);
    wait_clk(HALF);
    if (rd_full) begin
      chk("sdo_oe_hold", 32'(sdo_oe), 32'(RB));
      if (RB) begin
        if (rd_q.size() > 0) chk("rd_byte", 32'(rx), 32'(rd_q.pop_front()));
      end else begin
        chk("sdo_tied", 32'(rx), 32'h0);
      end
    end
    sen_n = 1'b1;
    wait_clk(8);
    chk("sdo_oe_off", 32'(sdo_oe), 32'h0);
  endtask

  task automatic wr_frame(input logic [6:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
    rd_addr = a[4:0];
    frame({1'b0, a, d}, 16, 0);
  endtask

  // Write scoreboard: pops on each wr_stb, checks width and old/new local-read timing
  logic       stb_prev = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] pend_val;
  always @(negedge clk) begin
    wr_exp_t e;
    if (pend) begin
      chk("rd_new", 32'(rd_data), 32'(pend_val));
      pend = 1'b0;
    end
    if (stb_prev) chk("stb_width", 32'(wr_stb), 32'h0);
    if (wr_stb && !stb_prev) begin
      chk("wr_q_depth", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        if (e.addr < 7'd32) begin
          if (rd_addr == e.addr[4:0]) begin
            chk("rd_old", 32'(rd_data), 32'(model[e.addr[4:0]]));
            pend = 1'b1;
            pend_val = e.data;
          end
          model[e.addr[4:0]] = e.data;
        end
      end
    end
    stb_prev = wr_stb;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic so;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    wait_clk(4);
    chk("rst_sdo", 32'(sdo), 32'h0);
    chk("rst_sdo_oe", 32'(sdo_oe), 32'h0);
    chk("rst_wr_stb", 32'(wr_stb), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    wait_clk(8);

    // Basic write then local readback
    wr_frame(7'h0A, 8'h5C);
    rd_addr = 5'd10;
    #1 chk("rd_a", 32'(rd_data), 32'h5C);

    // Read back the same register over SPI
    frame(16'h8A00, 16, 0);

    // Aborted write after 12 bits, then the full frame
    rd_addr = 5'd4;
    frame(16'h0433, 12, 0);
    #1 chk("abort_reg", 32'(rd_data), 32'h00);
    wr_frame(7'h04, 8'h33);
    rd_addr = 5'd4;
    #1 chk("rd_4", 32'(rd_data), 32'h33);

    // Out-of-range write: strobe only, aliased register untouched
    wr_frame(7'h47, 8'h11);
    rd_addr = 5'd7;
    #1 chk("oor_alias", 32'(rd_data), 32'h00);
    frame(16'hC700, 16, 0);

    // Read with 20 surplus clocks
    frame(16'h8A00, 16, 20);
    rd_addr = 5'd10;
    #1 chk("rd_a_again", 32'(rd_data), 32'h5C);

    // Reset in the middle of a read frame
    sen_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) xfer_bit(i == 0 ? 1'b1 : ((i == 4 || i == 6) ? 1'b1 : 1'b0), so);
    wait_clk(HALF);
    chk("mid_sdo_oe", 32'(sdo_oe), 32'(RB));
    rst = 1'b1;
    #1;
    chk("rst_mid_sdo_oe", 32'(sdo_oe), 32'h0);
    chk("rst_mid_sdo", 32'(sdo), 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    wait_clk(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) xfer_bit(1'b0, so);
    wait_clk(HALF);
    chk("post_rst_oe", 32'(sdo_oe), 32'h0);
    sen_n = 1'b1;
    wait_clk(8);
    rd_addr = 5'd10;
    #1 chk("rst_cleared", 32'(rd_data), 32'h00);
    wr_frame(7'h01, 8'hFF);
    rd_addr = 5'd1;
    #1 chk("rd_1", 32'(rd_data), 32'hFF);

    wait_clk(20);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
